// File: rtl/multi_event_counter_pkg.sv
// Shared opcode encoding and field widths for the multi-channel event counter.
package multi_event_counter_pkg;

    typedef enum logic [3:0] {
        OP_READ        = 4'd0,
        OP_CLEAR       = 4'd1,
        OP_CLEAR_ALL   = 4'd2,
        OP_STATUS      = 4'd3,
        OP_READ_CLEAR  = 4'd4,
        OP_SNAPSHOT    = 4'd5,
        OP_READ_SHADOW = 4'd6
    } ci_op_e;

    localparam int IDX_W = 5;

    function automatic logic op_clears_one(input logic [3:0] op);
        return (op == OP_CLEAR) || (op == OP_READ_CLEAR);
    endfunction

endpackage

// File: rtl/multi_event_counter_if.sv
// Custom-instruction port bundle between the CPU (master) and the event counter (slave).
interface multi_event_counter_if;

    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic [31:0] ciResult;
    logic        ciDone;

    modport master (
        output ciStart, ciCke, ciN, ciValueA, ciValueB,
        input  ciResult, ciDone
    );

    modport slave (
        input  ciStart, ciCke, ciN, ciValueA, ciValueB,
        output ciResult, ciDone
    );

endinterface

// File: rtl/multi_event_counter_channel.sv
// One event channel: level/edge qualification, saturating or wrapping counter,
// sticky overflow flag and a clear that never swallows a same-cycle event.
module event_counter_channel #(
    parameter int WIDTH    = 16,
    parameter bit EDGE     = 1'b0,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             event_in,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             prev_q, prev_d;
    logic             inc;
    logic [WIDTH-1:0] base;
    logic             base_ovf;

    always_comb begin
        prev_d   = event_in;
        inc      = EDGE ? (event_in & ~prev_q) : event_in;
        // Clear zeroes the starting point, so an event in the same cycle lands on top of it.
        base     = clear ? '0 : count_q;
        base_ovf = clear ? 1'b0 : ovf_q;
        count_d  = base;
        ovf_d    = base_ovf;
        if (inc) begin
            if (&base) begin
                ovf_d   = 1'b1;
                count_d = SATURATE ? base : '0;
            end else begin
                count_d = base + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            prev_q  <= prev_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/multi_event_counter.sv
// Multi-channel event counter read and cleared over the CI port.
// Optional shadow snapshot (opcodes 5/6) enabled by MULTI_EVENT_COUNTER_SNAPSHOT_EN.
module multi_event_counter
    import multi_event_counter_pkg::*;
#(
    parameter int          CUSTOM_INSTRUCTION_ID = 0,
    parameter int          NUM_CHANNELS          = 4,
    parameter int          COUNTER_WIDTH         = 16,
    parameter logic [31:0] EDGE_MASK             = 32'd0,
    parameter int          SATURATE              = 1
) (
    input  logic                    systemClock,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] eventIn,
    multi_event_counter_if.slave    ci
);

    logic                     accept;
    logic [3:0]               opcode;
    logic [IDX_W-1:0]         idx;
    logic                     idx_ok;
    logic [COUNTER_WIDTH-1:0] count [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  ovf;
    logic [NUM_CHANNELS-1:0]  clear;
    logic [COUNTER_WIDTH-1:0] sel_count;
    logic [31:0]              result_d, result_q;
    logic                     done_d, done_q;
    logic                     unused_ci_bits;

    assign accept = ci.ciStart & ci.ciCke & (ci.ciN == 8'(CUSTOM_INSTRUCTION_ID));
    assign opcode = ci.ciValueA[3:0];
    assign idx    = ci.ciValueB[IDX_W-1:0];
    assign idx_ok = 32'(idx) < 32'(NUM_CHANNELS);
    assign unused_ci_bits = ^{ci.ciValueA[31:4], ci.ciValueB[31:IDX_W]};

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        assign clear[i] = accept & ((opcode == OP_CLEAR_ALL) |
                                    (op_clears_one(opcode) & idx_ok & (32'(idx) == i)));

        event_counter_channel #(
            .WIDTH    (COUNTER_WIDTH),
            .EDGE     (EDGE_MASK[i]),
            .SATURATE (SATURATE != 0)
        ) u_chan (
            .clk      (systemClock),
            .rst      (reset),
            .event_in (eventIn[i]),
            .clear    (clear[i]),
            .count    (count[i]),
            .ovf      (ovf[i])
        );
    end

    always_comb begin
        sel_count = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (32'(idx) == i) sel_count = count[i];
        end
    end

`ifdef MULTI_EVENT_COUNTER_SNAPSHOT_EN
    logic [COUNTER_WIDTH-1:0] shadow_q [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] shadow_d [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] sel_shadow;

    // Snapshot captures pre-increment values, the same view a READ would give.
    always_comb begin
        shadow_d = shadow_q;
        if (accept && (opcode == OP_SNAPSHOT)) shadow_d = count;
        sel_shadow = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (32'(idx) == i) sel_shadow = shadow_q[i];
        end
    end

    always_ff @(posedge systemClock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) shadow_q[i] <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    always_comb begin
        result_d = '0;
        done_d   = accept;
        if (accept) begin
            case (opcode)
                OP_READ, OP_READ_CLEAR: if (idx_ok) result_d = 32'(sel_count);
                OP_STATUS:              result_d = 32'(ovf);
`ifdef MULTI_EVENT_COUNTER_SNAPSHOT_EN
                OP_READ_SHADOW:         if (idx_ok) result_d = 32'(sel_shadow);
`endif
                default:                result_d = '0;
            endcase
        end
    end

    always_ff @(posedge systemClock) begin
        if (reset) begin
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign ci.ciDone   = done_q;
    assign ci.ciResult = result_q;

endmodule
